// File: rtl/imem_responder_pkg.sv
// Shared defines (ADDR_WIDTH, INST_WIDTH, PC_RESET, RV_NOP) and types for imem_responder.
// Optional feature macro consumed by the top: IMEM_STALL_INJ_EN.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif
`ifndef PC_RESET
`define PC_RESET 32'h8000_0000
`endif
`ifndef RV_NOP
`define RV_NOP 32'h0000_0013
`endif

package imem_responder_pkg;

  localparam int ADDR_WIDTH = `ADDR_WIDTH;
  localparam int INST_WIDTH = `INST_WIDTH;
  localparam logic [INST_WIDTH-1:0] RV_NOP = `RV_NOP;
  localparam logic [7:0] LFSR_SEED = 8'hA5;

  typedef struct packed {
    logic                  err;
    logic [INST_WIDTH-1:0] inst;
  } resp_t;

  // Fibonacci LFSR step for x^8+x^6+x^5+x^4+1.
  function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
    return {cur[6:0], cur[7] ^ cur[5] ^ cur[4] ^ cur[3]};
  endfunction

endpackage

// File: rtl/imem_responder_lat_pipe.sv
// imem_lat_pipe: flushable valid+payload delay line of LATENCY stages with a synchronous clear.
module imem_lat_pipe #(
  parameter int WIDTH   = 33,
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             flush,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_vld,
  output logic [WIDTH-1:0] out_data
);

  logic             vld [LATENCY];
  logic [WIDTH-1:0] dat [LATENCY];

  // Payload only moves alongside a live valid, so the last stage holds between responses.
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < LATENCY; i++) begin
        vld[i] <= 1'b0;
        dat[i] <= '0;
      end
    end else begin
      vld[0] <= in_vld & ~flush;
      if (in_vld && !flush) begin
        dat[0] <= in_data;
      end
      for (int i = 1; i < LATENCY; i++) begin
        vld[i] <= vld[i-1] & ~flush;
        if (vld[i-1] && !flush) begin
          dat[i] <= dat[i-1];
        end
      end
    end
  end

  assign out_vld  = vld[LATENCY-1];
  assign out_data = dat[LATENCY-1];

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: fixed-latency word fetch with range/alignment errors, flush and loader port.
// Define IMEM_STALL_INJ_EN to throttle o_iaddr_rdy with an 8-bit LFSR.
module imem_responder
  import imem_responder_pkg::*;
#(
  parameter int                    DEPTH_WORDS = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = `PC_RESET,
  parameter int                    LATENCY     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] i_iaddr,
  input  logic                  i_iaddr_vld,
  output logic                  o_iaddr_rdy,
  output logic [INST_WIDTH-1:0] o_inst,
  output logic                  o_inst_vld,
  output logic                  o_inst_err,
  input  logic                  i_flush,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [INST_WIDTH-1:0] i_wr_data
);

  localparam int IDXW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [ADDR_WIDTH-1:0] DEPTH_L = DEPTH_WORDS;

  logic [INST_WIDTH-1:0] mem [DEPTH_WORDS];

  logic [ADDR_WIDTH-1:0] rd_off, wr_off;
  logic [IDXW-1:0]       rd_idx, wr_idx;
  logic                  rd_err, wr_err;
  logic                  accept;
  resp_t                 req_resp, out_resp;

  // BASE_ADDR is word aligned, so off[1:0] equals the address's own low bits.
  function automatic logic bad_addr(input logic [ADDR_WIDTH-1:0] addr,
                                    input logic [ADDR_WIDTH-1:0] off);
    return (off[1:0] != 2'b00) || (addr < BASE_ADDR) ||
           ({2'b00, off[ADDR_WIDTH-1:2]} >= DEPTH_L);
  endfunction

  // Decode fetch and loader addresses; erroring fetches never touch the array.
  always_comb begin
    rd_off = i_iaddr - BASE_ADDR;
    wr_off = i_wr_addr - BASE_ADDR;
    rd_idx = rd_off[IDXW+1:2];
    wr_idx = wr_off[IDXW+1:2];
    rd_err = bad_addr(i_iaddr, rd_off);
    wr_err = bad_addr(i_wr_addr, wr_off);
    req_resp.err = rd_err;
    if (rd_err) begin
      req_resp.inst = RV_NOP;
    end else begin
      req_resp.inst = mem[rd_idx];
    end
  end

  assign accept = i_iaddr_vld & o_iaddr_rdy;

  // Loader write; the fetch read above samples before this edge, giving read-first.
  always_ff @(posedge clk) begin
    if (i_wr_en && !wr_err) begin
      mem[wr_idx] <= i_wr_data;
    end
  end

`ifdef IMEM_STALL_INJ_EN
  logic [7:0] lfsr;

  // Stall-injection sequence, advancing every non-reset cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= lfsr_next(lfsr);
    end
  end

  assign o_iaddr_rdy = ~rst & (lfsr[1:0] != 2'b00);
`else
  assign o_iaddr_rdy = ~rst;
`endif

  imem_lat_pipe #(
    .WIDTH   ($bits(resp_t)),
    .LATENCY (LATENCY)
  ) u_pipe (
    .clk      (clk),
    .clr      (rst),
    .flush    (i_flush),
    .in_vld   (accept),
    .in_data  (req_resp),
    .out_vld  (o_inst_vld),
    .out_data (out_resp)
  );

  assign o_inst     = out_resp.inst;
  assign o_inst_err = out_resp.err;

endmodule

// File: tb/tb_imem_responder.sv
// Directed self-checking bench for imem_responder (LATENCY=2, DEPTH_WORDS=1024).
module tb_imem_responder;
  import imem_responder_pkg::*;

  localparam logic [31:0] BASE = `PC_RESET;
  localparam logic [31:0] W0   = 32'h0010_0093;
  localparam logic [31:0] W1   = 32'h0020_0113;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] i_iaddr = 32'h0;
  logic        i_iaddr_vld = 1'b0;
  logic        o_iaddr_rdy;
  logic [31:0] o_inst;
  logic        o_inst_vld;
  logic        o_inst_err;
  logic        i_flush = 1'b0;
  logic        i_wr_en = 1'b0;
  logic [31:0] i_wr_addr = 32'h0;
  logic [31:0] i_wr_data = 32'h0;

  int compared = 0;
  int mismatched = 0;

  imem_responder dut (
    .clk(clk), .rst(rst), .i_iaddr(i_iaddr), .i_iaddr_vld(i_iaddr_vld),
    .o_iaddr_rdy(o_iaddr_rdy), .o_inst(o_inst), .o_inst_vld(o_inst_vld),
    .o_inst_err(o_inst_err), .i_flush(i_flush), .i_wr_en(i_wr_en),
    .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    i_wr_en = 1'b1; i_wr_addr = a; i_wr_data = d;
    tick();
    i_wr_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    compared++; if (o_inst_vld !== 1'b0) begin mismatched++; $display("FAIL reset_vld got %0b want 0", o_inst_vld); end
    compared++; if (o_inst !== 32'h0) begin mismatched++; $display("FAIL reset_inst got %h want 0", o_inst); end
    compared++; if (o_inst_err !== 1'b0) begin mismatched++; $display("FAIL reset_err got %0b want 0", o_inst_err); end
    compared++; if (o_iaddr_rdy !== 1'b0) begin mismatched++; $display("FAIL reset_rdy got %0b want 0", o_iaddr_rdy); end
    rst = 1'b0;
    #1;
`ifndef IMEM_STALL_INJ_EN
    compared++; if (o_iaddr_rdy !== 1'b1) begin mismatched++; $display("FAIL post_reset_rdy got %0b want 1", o_iaddr_rdy); end
`endif
  endtask

  task automatic test_basic_read();
    load(BASE, W0);
    load(BASE + 32'd4, W1);
    i_iaddr_vld = 1'b1; i_iaddr = BASE;
    tick();
    i_iaddr = BASE + 32'd4;
    compared++; if (o_inst_vld !== 1'b0) begin mismatched++; $display("FAIL early_vld got %0b want 0", o_inst_vld); end
    tick();
    i_iaddr_vld = 1'b0;
    compared++; if (o_inst_vld !== 1'b1 || o_inst !== W0 || o_inst_err !== 1'b0) begin
      mismatched++; $display("FAIL read0 got vld=%0b inst=%h err=%0b want 1/%h/0", o_inst_vld, o_inst, o_inst_err, W0); end
    tick();
    compared++; if (o_inst_vld !== 1'b1 || o_inst !== W1 || o_inst_err !== 1'b0) begin
      mismatched++; $display("FAIL read1 got vld=%0b inst=%h err=%0b want 1/%h/0", o_inst_vld, o_inst, o_inst_err, W1); end
    tick();
    compared++; if (o_inst_vld !== 1'b0 || o_inst !== W1) begin
      mismatched++; $display("FAIL hold got vld=%0b inst=%h want 0/%h", o_inst_vld, o_inst, W1); end
  endtask

  task automatic test_errors();
    logic [31:0] addrs [4];
    logic        errs  [4];
    addrs[0] = BASE + 32'd2;          errs[0] = 1'b1;
    addrs[1] = BASE + 32'h0000_1000;  errs[1] = 1'b1;
    addrs[2] = BASE - 32'd4;          errs[2] = 1'b1;
    addrs[3] = BASE + 32'h0000_0FFC;  errs[3] = 1'b0;
    load(BASE + 32'h0000_0FFC, 32'hCAFE_0001);
    for (int i = 0; i < 4; i++) begin
      i_iaddr_vld = 1'b1; i_iaddr = addrs[i];
      tick();
      i_iaddr_vld = 1'b0;
      tick();
      compared++;
      if (o_inst_vld !== 1'b1 || o_inst_err !== errs[i] ||
          o_inst !== (errs[i] ? NOP : 32'hCAFE_0001)) begin
        mismatched++;
        $display("FAIL err_case%0d addr=%h got vld=%0b err=%0b inst=%h want err=%0b",
                 i, addrs[i], o_inst_vld, o_inst_err, o_inst, errs[i]);
      end
    end
  endtask

  task automatic test_flush();
    i_iaddr_vld = 1'b1; i_iaddr = BASE;
    tick();
    i_iaddr = BASE + 32'd4; i_flush = 1'b1;
    tick();
    i_flush = 1'b0; i_iaddr = BASE;
    compared++; if (o_inst_vld !== 1'b0) begin mismatched++; $display("FAIL flush_t2 got vld=%0b want 0", o_inst_vld); end
    tick();
    i_iaddr_vld = 1'b0;
    compared++; if (o_inst_vld !== 1'b0) begin mismatched++; $display("FAIL flush_t3 got vld=%0b want 0", o_inst_vld); end
    tick();
    compared++; if (o_inst_vld !== 1'b1 || o_inst !== W0) begin
      mismatched++; $display("FAIL flush_t4 got vld=%0b inst=%h want 1/%h", o_inst_vld, o_inst, W0); end
    tick();
  endtask

  task automatic test_read_first();
    load(BASE + 32'd8, 32'h1234_5678);
    i_wr_en = 1'b1; i_wr_addr = BASE + 32'd8; i_wr_data = 32'hDEAD_BEEF;
    i_iaddr_vld = 1'b1; i_iaddr = BASE + 32'd8;
    tick();
    i_wr_en = 1'b0; i_iaddr_vld = 1'b0;
    tick();
    compared++; if (o_inst_vld !== 1'b1 || o_inst !== 32'h1234_5678) begin
      mismatched++; $display("FAIL read_first_old got vld=%0b inst=%h want 1/12345678", o_inst_vld, o_inst); end
    load(BASE + 32'd9, 32'h0BAD_0BAD);
    load(BASE + 32'h0000_1008, 32'h0BAD_0BAD);
    i_iaddr_vld = 1'b1;
    tick();
    i_iaddr_vld = 1'b0;
    tick();
    compared++; if (o_inst_vld !== 1'b1 || o_inst !== 32'hDEAD_BEEF) begin
      mismatched++; $display("FAIL read_first_new got vld=%0b inst=%h want 1/deadbeef", o_inst_vld, o_inst); end
    i_iaddr = BASE + 32'd12;
    i_iaddr_vld = 1'b1;
    tick();
    i_iaddr_vld = 1'b0;
    tick();
    compared++; if (o_inst_err !== 1'b0) begin
      mismatched++; $display("FAIL bad_write_neighbour got err=%0b want 0", o_inst_err); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [4];
    logic [31:0] exp_d [4];
    logic        exp_e [4];
    addrs[0] = BASE;                 exp_d[0] = W0;            exp_e[0] = 1'b0;
    addrs[1] = BASE + 32'd4;         exp_d[1] = W1;            exp_e[1] = 1'b0;
    addrs[2] = BASE + 32'd8;         exp_d[2] = 32'hDEAD_BEEF; exp_e[2] = 1'b0;
    addrs[3] = BASE + 32'h0000_1000; exp_d[3] = NOP;           exp_e[3] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      i_iaddr_vld = (i < 4);
      if (i < 4) i_iaddr = addrs[i];
      tick();
      if (i >= 1 && i <= 4) begin
        compared++;
        if (o_inst_vld !== 1'b1 || o_inst !== exp_d[i-1] || o_inst_err !== exp_e[i-1]) begin
          mismatched++;
          $display("FAIL b2b%0d got vld=%0b inst=%h err=%0b want 1/%h/%0b",
                   i - 1, o_inst_vld, o_inst, o_inst_err, exp_d[i-1], exp_e[i-1]);
        end
      end
    end
  endtask

  task automatic test_reset_midflight();
    i_iaddr_vld = 1'b1; i_iaddr = BASE;
    tick();
    i_iaddr_vld = 1'b0; rst = 1'b1;
    #1;
    compared++; if (o_iaddr_rdy !== 1'b0) begin mismatched++; $display("FAIL midrst_rdy got %0b want 0", o_iaddr_rdy); end
    tick();
    rst = 1'b0;
    for (int i = 2; i <= 4; i++) begin
      compared++;
      if (o_inst_vld !== 1'b0) begin mismatched++; $display("FAIL midrst_vld_t%0d got %0b want 0", i, o_inst_vld); end
      tick();
    end
  endtask

`ifdef IMEM_STALL_INJ_EN
  task automatic test_stall();
    logic [7:0]  lfsr;
    logic [31:0] expq [$];
    logic [31:0] got;
    int          acc;
    int          resp;
    logic        exp_rdy;
    load(BASE, W0);
    load(BASE + 32'd4, W1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    lfsr = 8'hA5; acc = 0; resp = 0;
    for (int c = 0; c < 204; c++) begin
      i_iaddr_vld = (c < 200);
      i_iaddr = BASE + ((acc % 2 == 1) ? 32'd4 : 32'd0);
      #1;
      exp_rdy = (lfsr[1:0] != 2'b00);
      compared++;
      if (o_iaddr_rdy !== exp_rdy) begin
        mismatched++; $display("FAIL stall_rdy c=%0d got %0b want %0b", c, o_iaddr_rdy, exp_rdy);
      end
      if (i_iaddr_vld && exp_rdy) begin
        expq.push_back((acc % 2 == 1) ? W1 : W0);
        acc++;
      end
      tick();
      lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      if (o_inst_vld === 1'b1) begin
        resp++;
        got = (expq.size() > 0) ? expq.pop_front() : 32'hFFFF_FFFF;
        compared++;
        if (o_inst !== got) begin
          mismatched++; $display("FAIL stall_order got %h want %h", o_inst, got);
        end
      end
    end
    compared++;
    if (resp != acc) begin mismatched++; $display("FAIL stall_count got %0d want %0d", resp, acc); end
  endtask
`endif

  initial begin
    test_reset();
`ifdef IMEM_STALL_INJ_EN
    test_stall();
`else
    test_basic_read();
    test_errors();
    test_flush();
    test_read_first();
    test_back_to_back();
    test_reset_midflight();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
